// File: rtl/codebook_b1_f_dec.sv
// ============================================================================
// codebook_b1_f_dec : bit-serial decoder for codebook-1 flush codewords
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module codebook_b1_f_dec #(
   parameter int CODEBOOK_LENGTH_MAX = 64,
   parameter int ENCODE_DATALENGTH   = 21
) (
   input  logic                           clk_i,
   input  logic                           rst_n_i,
   input  logic                           clear_i,
   input  logic                           bit_i,
   input  logic                           bit_valid_i,
   output logic                           bit_ready_o,
   output logic                           dec_valid_o,
   input  logic                           dec_ready_i,
   output logic [5:0]                     dec_cnt_o,
   output logic [CODEBOOK_LENGTH_MAX-1:0] dec_data_o,
   output logic [5:0]                     dec_length_o,
   output logic                           dec_err_o
);

   typedef enum logic [1:0] {
      ST_ACC  = 2'd0,
      ST_HOLD = 2'd1,
      ST_ERR  = 2'd2
   } state_e;

   state_e                          state_q, state_d;
   logic [ENCODE_DATALENGTH-1:0]    acc_q, acc_d;
   logic [5:0]                      cnt_q, cnt_d;
   logic [5:0]                      dec_cnt_q, dec_cnt_d;
   logic [CODEBOOK_LENGTH_MAX-1:0]  dec_data_q, dec_data_d;
   logic [5:0]                      dec_len_q, dec_len_d;

   logic [ENCODE_DATALENGTH-1:0]    acc_shift;
   logic [5:0]                      cnt_inc;
   logic                            hit;
   logic [5:0]                      hit_cnt;
   logic [11:0]                     hit_data;

   // Table match on the accumulator as it will be after accepting bit_i.
   always_comb begin
      acc_shift = (acc_q << 1) | ENCODE_DATALENGTH'(bit_i);
      cnt_inc   = cnt_q + 6'd1;
      hit       = 1'b0;
      hit_cnt   = 6'd0;
      hit_data  = 12'h000;
      case (cnt_inc)
         6'd6: if (acc_shift[5:0] == 6'b101101) begin
            hit = 1'b1; hit_cnt = 6'd1; hit_data = 12'h00F;
         end
         6'd8: if (acc_shift[7:0] == 8'b11010100) begin
            hit = 1'b1; hit_cnt = 6'd2; hit_data = 12'h00F;
         end
         6'd9: case (acc_shift[8:0])
            9'b111010101: begin hit = 1'b1; hit_cnt = 6'd2; hit_data = 12'h02F; end
            9'b111010010: begin hit = 1'b1; hit_cnt = 6'd2; hit_data = 12'h01F; end
            default: ;
         endcase
         6'd11: case (acc_shift[10:0])
            11'b11111100101: begin hit = 1'b1; hit_cnt = 6'd3; hit_data = 12'h00F; end
            11'b11111100111: begin hit = 1'b1; hit_cnt = 6'd3; hit_data = 12'h03F; end
            11'b11111101010: begin hit = 1'b1; hit_cnt = 6'd3; hit_data = 12'h04F; end
            default: ;
         endcase
         6'd12: case (acc_shift[11:0])
            12'b111111101001: begin hit = 1'b1; hit_cnt = 6'd2; hit_data = 12'h0AF; end
            12'b111111111000: begin hit = 1'b1; hit_cnt = 6'd3; hit_data = 12'h23F; end
            12'b111111110000: begin hit = 1'b1; hit_cnt = 6'd3; hit_data = 12'h13F; end
            12'b111111110011: begin hit = 1'b1; hit_cnt = 6'd3; hit_data = 12'h15F; end
            default: ;
         endcase
         6'd13: case (acc_shift[12:0])
            13'b1111111111111: begin hit = 1'b1; hit_cnt = 6'd3; hit_data = 12'h25F; end
            13'b1111111111100: begin hit = 1'b1; hit_cnt = 6'd3; hit_data = 12'h16F; end
            default: ;
         endcase
         default: ;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      dec_cnt_d  = dec_cnt_q;
      dec_data_d = dec_data_q;
      dec_len_d  = dec_len_q;
      case (state_q)
         ST_ACC: begin
            if (bit_valid_i) begin
               if (hit) begin
                  state_d    = ST_HOLD;
                  acc_d      = '0;
                  cnt_d      = 6'd0;
                  dec_cnt_d  = hit_cnt;
                  dec_data_d = CODEBOOK_LENGTH_MAX'(hit_data);
                  dec_len_d  = cnt_inc;
               end else begin
                  acc_d = acc_shift;
                  cnt_d = cnt_inc;
                  if (cnt_inc == 6'd13) begin
                     state_d = ST_ERR;
                  end
               end
            end
         end
         ST_HOLD: begin
            if (dec_ready_i) begin
               state_d = ST_ACC;
            end
         end
         ST_ERR: ;
         default: state_d = ST_ACC;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i || clear_i) begin
         state_q    <= ST_ACC;
         acc_q      <= '0;
         cnt_q      <= 6'd0;
         dec_cnt_q  <= 6'd0;
         dec_data_q <= '0;
         dec_len_q  <= 6'd0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         dec_cnt_q  <= dec_cnt_d;
         dec_data_q <= dec_data_d;
         dec_len_q  <= dec_len_d;
      end
   end

   assign bit_ready_o  = (state_q == ST_ACC);
   assign dec_valid_o  = (state_q == ST_HOLD);
   assign dec_err_o    = (state_q == ST_ERR);
   assign dec_cnt_o    = dec_cnt_q;
   assign dec_data_o   = dec_data_q;
   assign dec_length_o = dec_len_q;

endmodule

`default_nettype wire

// File: tb/tb_codebook_b1_f_dec.sv
// ============================================================================
// tb_codebook_b1_f_dec : randomized self-checking bench for codebook_b1_f_dec
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_codebook_b1_f_dec;

   localparam int CLM = 64;
   localparam int EDL = 21;

   logic            clk_i = 1'b0;
   logic            rst_n_i = 1'b0;
   logic            clear_i = 1'b0;
   logic            bit_i = 1'b0;
   logic            bit_valid_i = 1'b0;
   logic            bit_ready_o;
   logic            dec_valid_o;
   logic            dec_ready_i = 1'b1;
   logic [5:0]      dec_cnt_o;
   logic [CLM-1:0]  dec_data_o;
   logic [5:0]      dec_length_o;
   logic            dec_err_o;

   always #5 clk_i = ~clk_i;

   codebook_b1_f_dec #(
      .CODEBOOK_LENGTH_MAX (CLM),
      .ENCODE_DATALENGTH   (EDL)
   ) dut (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .clear_i      (clear_i),
      .bit_i        (bit_i),
      .bit_valid_i  (bit_valid_i),
      .bit_ready_o  (bit_ready_o),
      .dec_valid_o  (dec_valid_o),
      .dec_ready_i  (dec_ready_i),
      .dec_cnt_o    (dec_cnt_o),
      .dec_data_o   (dec_data_o),
      .dec_length_o (dec_length_o),
      .dec_err_o    (dec_err_o)
   );

   // Codeword table: length, bits (MSB first = bit len-1), symbol count, data.
   int          t_len  [13] = '{6, 8, 9, 9, 12, 11, 11, 11, 12, 12, 12, 13, 13};
   logic [12:0] t_code [13] = '{13'b101101, 13'b11010100, 13'b111010101, 13'b111010010,
                                13'b111111101001, 13'b11111100101, 13'b11111100111,
                                13'b11111101010, 13'b111111111000, 13'b111111110000,
                                13'b111111110011, 13'b1111111111111, 13'b1111111111100};
   int          t_cnt  [13] = '{1, 2, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3, 3};
   logic [11:0] t_data [13] = '{12'hF, 12'h0F, 12'h2F, 12'h1F, 12'hAF, 12'h00F, 12'h03F,
                                12'h04F, 12'h23F, 12'h13F, 12'h15F, 12'h25F, 12'h16F};

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: 0 = collecting bits, 1 = entry waiting, 2 = error.
   int          m_mode = 0;
   bit          m_q [$];
   logic [5:0]  m_cnt = 6'd0;
   logic [63:0] m_data = 64'd0;
   logic [5:0]  m_len = 6'd0;
   int          sb [$];
   int          dr_mode = 0;
   int          gap_mode = 0;
   bit          tog = 1'b0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int lookup();
      for (int i = 0; i < 13; i++) begin
         if (t_len[i] == m_q.size()) begin
            bit ok = 1'b1;
            for (int j = 0; j < t_len[i]; j++)
               if (m_q[j] != t_code[i][t_len[i]-1-j]) ok = 1'b0;
            if (ok) return i;
         end
      end
      return -1;
   endfunction

   task automatic tick();
      int k;
      case (dr_mode)
         0:       dec_ready_i = 1'b1;
         1:       dec_ready_i = (($urandom % 3) != 0);
         default: dec_ready_i = 1'b0;
      endcase
      if (rst_n_i && !clear_i && dec_valid_o && dec_ready_i) begin
         if (sb.size() == 0) begin
            check_eq("unexpected_entry", 64'd1, 64'd0);
         end else begin
            k = sb.pop_front();
            check_eq("sb_cnt",  64'(dec_cnt_o),    64'(t_cnt[k]));
            check_eq("sb_data", 64'(dec_data_o),   64'(t_data[k]));
            check_eq("sb_len",  64'(dec_length_o), 64'(t_len[k]));
         end
      end
      @(posedge clk_i);
      if (!rst_n_i || clear_i) begin
         m_mode = 0; m_q.delete(); m_cnt = 6'd0; m_data = 64'd0; m_len = 6'd0; sb.delete();
      end else if (m_mode == 0 && bit_valid_i) begin
         m_q.push_back(bit_i);
         k = lookup();
         if (k >= 0) begin
            m_mode = 1; m_cnt = 6'(t_cnt[k]); m_data = 64'(t_data[k]); m_len = 6'(t_len[k]);
            m_q.delete();
         end else if (m_q.size() == 13) begin
            m_mode = 2;
         end
      end else if (m_mode == 1 && dec_ready_i) begin
         m_mode = 0;
      end
      @(negedge clk_i);
      check_eq("bit_ready", 64'(bit_ready_o),  64'(m_mode == 0));
      check_eq("dec_valid", 64'(dec_valid_o),  64'(m_mode == 1));
      check_eq("dec_err",   64'(dec_err_o),    64'(m_mode == 2));
      check_eq("dec_cnt",   64'(dec_cnt_o),    64'(m_cnt));
      check_eq("dec_data",  64'(dec_data_o),   m_data);
      check_eq("dec_len",   64'(dec_length_o), 64'(m_len));
   endtask

   task automatic idle(input int n);
      bit_valid_i = 1'b0;
      repeat (n) tick();
   endtask

   task automatic send_bit(input logic b);
      bit taken = 1'b0;
      bit_i = b;
      for (int t = 0; t < 1000 && !taken; t++) begin
         case (gap_mode)
            0:       bit_valid_i = 1'b1;
            1:       bit_valid_i = (($urandom % 4) != 0);
            default: begin tog = ~tog; bit_valid_i = tog; end
         endcase
         taken = bit_valid_i && (m_mode == 0);
         tick();
      end
      if (!taken) check_eq("bit_accept_timeout", 64'd0, 64'd1);
      bit_valid_i = 1'b0;
   endtask

   task automatic send_raw(input logic [12:0] v, input int len);
      for (int j = len - 1; j >= 0; j--) send_bit(v[j]);
   endtask

   task automatic send_code(input int i);
      sb.push_back(i);
      send_raw(t_code[i], t_len[i]);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      @(negedge clk_i);
      rst_n_i = 1'b0;
      repeat (3) tick();
      rst_n_i = 1'b1;
      idle(2);

      // Single shortest codeword, continuous, always ready
      dr_mode = 0; gap_mode = 0;
      send_code(0);
      idle(3);

      // All codewords back-to-back with stalls on both sides
      dr_mode = 1; gap_mode = 1;
      for (int i = 0; i < 13; i++) send_code(i);
      dr_mode = 0;
      idle(5);

      // Unmatched 13-bit stream, then clear, then a good codeword
      gap_mode = 0;
      send_raw(13'b1111111111010, 13);
      idle(3);
      clear_i = 1'b1; tick(); clear_i = 1'b0;
      send_code(1);
      idle(3);

      // Reset in the middle of a codeword
      send_raw(13'b1111111, 7);
      rst_n_i = 1'b0; tick(); rst_n_i = 1'b1;
      send_code(3);
      idle(3);

      // Toggling bit valid
      gap_mode = 2; tog = 1'b0;
      send_code(12);
      idle(3);

      // Clear while an entry is held and not consumed
      gap_mode = 0; dr_mode = 2;
      send_code(5);
      idle(3);
      clear_i = 1'b1; tick(); clear_i = 1'b0;
      dr_mode = 0;
      idle(3);

      // Random codeword traffic, occasional garbage followed by clear
      dr_mode = 1; gap_mode = 1;
      for (int r = 0; r < 60; r++) begin
         if (($urandom % 10) == 0) begin
            dr_mode = 0;
            idle(4);
            send_raw(13'($urandom), 1 + int'($urandom % 13));
            clear_i = 1'b1; tick(); clear_i = 1'b0;
            dr_mode = 1;
         end else begin
            send_code(int'($urandom % 13));
         end
      end
      dr_mode = 0;
      idle(5);

      check_eq("sb_drained", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
